// File: rtl/ghostbus_pkg.sv
// Shared types and defaults for the ghostbus requester arbiter.
package ghostbus_pkg;
  localparam int GB_DEF_AW = 12;
  localparam int GB_DEF_DW = 32;
  localparam int GB_CNT_W  = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} gb_arb_state_t;
endpackage

// File: rtl/ghostbus_rr_arb.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr, wrapping.
module ghostbus_rr_arb #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic            any_valid
);
  int idx;

  // Scan from the farthest offset down so the nearest valid requester wins last.
  always_comb begin
    grant = '0;
    idx   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (valid[idx]) grant = NREQ'(1) << idx;
    end
    any_valid = |valid;
  end
endmodule

// File: rtl/ghostbus_arbiter.sv
// Round-robin sharing of one ghostbus host port among NREQ single-word requesters.
// state | meaning
// IDLE  | park IDLE_ADDR on the bus, offer ready to the round-robin winner
// ISSUE | drive latched addr/wdata, gb_we for writes
// WAIT  | hold addr, count down RD_LAT, capture gb_din on the last count
// DONE  | pulse rsp_valid to the owner
module ghostbus_arbiter
  import ghostbus_pkg::*;
#(
  parameter int            NREQ      = 2,
  parameter int            AW        = GB_DEF_AW,
  parameter int            DW        = GB_DEF_DW,
  parameter int            RD_LAT    = 1,
  parameter logic [AW-1:0] IDLE_ADDR = '0
) (
  input  logic             gb_clk,
  input  logic             gb_rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               busy,
  output logic [AW-1:0]      gb_addr,
  output logic [DW-1:0]      gb_dout,
  output logic               gb_we,
  input  logic [DW-1:0]      gb_din
);
  localparam int PW = $clog2(NREQ);

  gb_arb_state_t       state;
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       owner;
  logic [PW-1:0]       gidx;
  logic                we_q;
  logic [AW-1:0]       addr_q;
  logic [GB_CNT_W-1:0] cnt;
  logic [NREQ-1:0]     grant;
  logic                any_valid;

  ghostbus_rr_arb #(.NREQ(NREQ), .PW(PW)) u_rr_arb (
    .valid     (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .any_valid (any_valid)
  );

  always_comb begin
    gidx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) gidx = PW'(k);
    end
  end

  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      we_q      <= 1'b0;
      addr_q    <= IDLE_ADDR;
      gb_dout   <= '0;
      cnt       <= '0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            owner   <= gidx;
            we_q    <= req_we[gidx];
            addr_q  <= req_addr[gidx*AW +: AW];
            gb_dout <= req_wdata[gidx*DW +: DW];
            rr_ptr  <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (we_q) begin
            state <= DONE;
          end else begin
            cnt   <= GB_CNT_W'(RD_LAT);
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == GB_CNT_W'(1)) begin
            rsp_rdata <= gb_din;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus-side outputs decode straight from flops so reset clears them asynchronously.
  assign busy      = (state != IDLE);
  assign gb_we     = (state == ISSUE) && we_q;
  assign gb_addr   = (state == IDLE) ? IDLE_ADDR : addr_q;
  assign rsp_valid = (state == DONE) ? (NREQ'(1) << owner) : '0;
  assign req_ready = (state == IDLE) ? grant : '0;
endmodule

// File: tb/tb_ghostbus_arbiter.sv
// Directed bench for ghostbus_arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_ghostbus_arbiter;
  logic        gb_clk = 1'b0;
  logic        gb_rst_n = 1'b0;
  logic [1:0]  req_valid = '0, req_we = '0, req_ready, rsp_valid;
  logic [23:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [31:0] rsp_rdata, gb_dout, gb_din;
  logic        busy, gb_we;
  logic [11:0] gb_addr;

  logic [1:0]  v3 = '0, we3 = '0, ready3, rsp3;
  logic [23:0] a3 = '0;
  logic [63:0] d3 = '0;
  logic [31:0] rdata3, dout3, din3;
  logic        busy3, gbwe3;
  logic [11:0] addr3;

  logic [11:0] p1 = '0, p3a = '0, p3b = '0, p3c = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 gb_clk = ~gb_clk;

  function automatic logic [31:0] mem(input logic [11:0] a);
    case (a)
      12'h000: mem = 32'h42;
      12'h200: mem = 32'hA5A5;
      12'h400: mem = 32'h1234;
      default: mem = {20'h0, a} ^ 32'hDEAD0000;
    endcase
  endfunction

  // Bus models: read data appears RD_LAT cycles after the address.
  always @(posedge gb_clk) begin
    p1  <= gb_addr;
    p3a <= addr3;
    p3b <= p3a;
    p3c <= p3b;
  end
  assign gb_din = mem(p1);
  assign din3   = mem(p3c);

  ghostbus_arbiter #(.NREQ(2), .AW(12), .DW(32), .RD_LAT(1), .IDLE_ADDR(12'h000)) dut (
    .gb_clk(gb_clk), .gb_rst_n(gb_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .gb_addr(gb_addr), .gb_dout(gb_dout), .gb_we(gb_we), .gb_din(gb_din)
  );

  ghostbus_arbiter #(.NREQ(2), .AW(12), .DW(32), .RD_LAT(3), .IDLE_ADDR(12'h000)) dut3 (
    .gb_clk(gb_clk), .gb_rst_n(gb_rst_n),
    .req_valid(v3), .req_ready(ready3), .req_we(we3),
    .req_addr(a3), .req_wdata(d3),
    .rsp_valid(rsp3), .rsp_rdata(rdata3), .busy(busy3),
    .gb_addr(addr3), .gb_dout(dout3), .gb_we(gbwe3), .gb_din(din3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  we;
    logic [11:0] a0, a1;
    logic [31:0] d0, d1;
    logic [1:0]  e_ready;
    logic        e_busy;
    logic        e_we;
    logic [11:0] e_addr;
    logic [31:0] e_dout;
    logic [1:0]  e_rsp;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vq[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_hs, r0, r1, viol, last, stray, held, rsp_cyc;
    logic [11:0] ra;
    logic [31:0] rd;

    // valid we  a0      a1      d0     d1     | ready busy we addr    dout   rsp   rdata
    vq.push_back(vec_t'{2'b00, 2'b00, 12'h000, 12'h000, 32'h0, 32'h00, 2'b00, 1'b0, 1'b0, 12'h000, 32'h00, 2'b00, 32'h00});
    vq.push_back(vec_t'{2'b01, 2'b01, 12'h040, 12'h000, 32'h5, 32'h77, 2'b01, 1'b0, 1'b0, 12'h000, 32'h00, 2'b00, 32'h00});
    vq.push_back(vec_t'{2'b00, 2'b00, 12'h040, 12'h000, 32'h5, 32'h77, 2'b00, 1'b1, 1'b1, 12'h040, 32'h05, 2'b00, 32'h00});
    vq.push_back(vec_t'{2'b00, 2'b00, 12'h040, 12'h000, 32'h5, 32'h77, 2'b00, 1'b1, 1'b0, 12'h040, 32'h05, 2'b01, 32'h00});
    vq.push_back(vec_t'{2'b00, 2'b00, 12'h040, 12'h000, 32'h5, 32'h77, 2'b00, 1'b0, 1'b0, 12'h000, 32'h05, 2'b00, 32'h00});
    vq.push_back(vec_t'{2'b10, 2'b00, 12'h040, 12'h000, 32'h5, 32'h77, 2'b10, 1'b0, 1'b0, 12'h000, 32'h05, 2'b00, 32'h00});
    vq.push_back(vec_t'{2'b00, 2'b00, 12'h040, 12'h000, 32'h5, 32'h77, 2'b00, 1'b1, 1'b0, 12'h000, 32'h77, 2'b00, 32'h00});
    vq.push_back(vec_t'{2'b00, 2'b00, 12'h040, 12'h000, 32'h5, 32'h77, 2'b00, 1'b1, 1'b0, 12'h000, 32'h77, 2'b00, 32'h00});
    vq.push_back(vec_t'{2'b01, 2'b01, 12'h010, 12'h000, 32'hA, 32'h77, 2'b00, 1'b1, 1'b0, 12'h000, 32'h77, 2'b10, 32'h42});
    vq.push_back(vec_t'{2'b11, 2'b11, 12'h010, 12'h020, 32'hA, 32'hB,  2'b01, 1'b0, 1'b0, 12'h000, 32'h77, 2'b00, 32'h42});
    vq.push_back(vec_t'{2'b11, 2'b11, 12'h010, 12'h020, 32'hA, 32'hB,  2'b00, 1'b1, 1'b1, 12'h010, 32'h0A, 2'b00, 32'h42});
    vq.push_back(vec_t'{2'b11, 2'b11, 12'h010, 12'h020, 32'hA, 32'hB,  2'b00, 1'b1, 1'b0, 12'h010, 32'h0A, 2'b01, 32'h42});
    vq.push_back(vec_t'{2'b11, 2'b11, 12'h010, 12'h020, 32'hA, 32'hB,  2'b10, 1'b0, 1'b0, 12'h000, 32'h0A, 2'b00, 32'h42});
    vq.push_back(vec_t'{2'b00, 2'b11, 12'h010, 12'h020, 32'hA, 32'hB,  2'b00, 1'b1, 1'b1, 12'h020, 32'h0B, 2'b00, 32'h42});
    vq.push_back(vec_t'{2'b00, 2'b11, 12'h010, 12'h020, 32'hA, 32'hB,  2'b00, 1'b1, 1'b0, 12'h020, 32'h0B, 2'b10, 32'h42});
    vq.push_back(vec_t'{2'b00, 2'b00, 12'h010, 12'h020, 32'hA, 32'hB,  2'b00, 1'b0, 1'b0, 12'h000, 32'h0B, 2'b00, 32'h42});
    vq.push_back(vec_t'{2'b00, 2'b00, 12'h010, 12'h020, 32'hA, 32'hB,  2'b00, 1'b0, 1'b0, 12'h000, 32'h0B, 2'b00, 32'h42});

    repeat (2) @(negedge gb_clk);
    gb_rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge gb_clk);
      req_valid = vq[i].valid;
      req_we    = vq[i].we;
      req_addr  = {vq[i].a1, vq[i].a0};
      req_wdata = {vq[i].d1, vq[i].d0};
      #1;
      chk($sformatf("v%0d ready", i), req_ready, vq[i].e_ready);
      chk($sformatf("v%0d busy", i),  busy,      vq[i].e_busy);
      chk($sformatf("v%0d gb_we", i), gb_we,     vq[i].e_we);
      chk($sformatf("v%0d addr", i),  gb_addr,   vq[i].e_addr);
      chk($sformatf("v%0d dout", i),  gb_dout,   vq[i].e_dout);
      chk($sformatf("v%0d rsp", i),   rsp_valid, vq[i].e_rsp);
      chk($sformatf("v%0d rdata", i), rsp_rdata, vq[i].e_rdata);
    end

    // Both requesters held valid for 8 writes: grants must alternate starting at 0.
    n_hs = 0; r0 = 0; r1 = 0; viol = 0; last = 0;
    req_we = 2'b11;
    req_addr = {12'h180, 12'h100};
    req_wdata = {32'hB1, 32'hA1};
    for (int c = 0; c < 60 && (r0 + r1) < 8; c++) begin
      @(negedge gb_clk);
      req_valid = (n_hs < 8) ? 2'b11 : 2'b00;
      #1;
      if (req_ready != 2'b00) begin
        chk($sformatf("fair grant %0d", n_hs), req_ready, (n_hs % 2 == 1) ? 2'b10 : 2'b01);
        last = int'(req_ready[1]);
        n_hs++;
      end
      if (gb_we) chk("fair addr", gb_addr, (last == 1) ? 12'h180 : 12'h100);
      if ((busy && req_ready != 2'b00) || $countones(rsp_valid) > 1 || $countones(req_ready) > 1)
        viol++;
      if (rsp_valid[0]) r0++;
      if (rsp_valid[1]) r1++;
    end
    chk("fair handshakes", n_hs, 8);
    chk("fair rsp0", r0, 4);
    chk("fair rsp1", r1, 4);
    chk("fair overlap", viol, 0);

    // Reset in WAIT: outputs clear at once, no response, rr_ptr back to 0.
    @(negedge gb_clk);
    req_valid = 2'b01; req_we = 2'b00; req_addr = {12'h000, 12'h300};
    #1;
    chk("rst read ready", req_ready, 2'b01);
    @(negedge gb_clk);
    req_valid = 2'b00;
    @(negedge gb_clk);
    #1;
    chk("rst pre busy", busy, 1'b1);
    gb_rst_n = 1'b0;
    #1;
    chk("rst busy", busy, 1'b0);
    chk("rst gb_we", gb_we, 1'b0);
    chk("rst rsp", rsp_valid, 2'b00);
    chk("rst addr", gb_addr, 12'h000);
    @(negedge gb_clk);
    gb_rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge gb_clk);
      #1;
      if (rsp_valid != 2'b00) stray++;
    end
    chk("rst lost rsp", stray, 0);
    @(negedge gb_clk);
    req_valid = 2'b11; req_we = 2'b11; req_addr = {12'h0AA, 12'h055};
    req_wdata = {32'hC2, 32'hC1};
    #1;
    chk("rst rr_ptr", req_ready, 2'b01);
    req_valid = 2'b10;
    #1;
    chk("rst req1 ready", req_ready, 2'b10);
    @(negedge gb_clk);
    req_valid = 2'b00;
    #1;
    chk("rst req1 addr", gb_addr, 12'h0AA);
    chk("rst req1 we", gb_we, 1'b1);
    @(negedge gb_clk);
    #1;
    chk("rst req1 rsp", rsp_valid, 2'b10);

    // Idle bus for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      @(negedge gb_clk);
      #1;
      chk($sformatf("idle %0d", c), {gb_addr, gb_we, req_ready}, 15'h0);
    end

    // RD_LAT=3 reads: address held 5 cycles, response in cycle 5 after handshake.
    for (int r = 0; r < 2; r++) begin
      ra = (r == 1) ? 12'h400 : 12'h200;
      rd = (r == 1) ? 32'h1234 : 32'hA5A5;
      @(negedge gb_clk);
      v3 = 2'b01 << r; we3 = 2'b00; a3 = {ra, ra};
      #1;
      chk($sformatf("lat3 ready %0d", r), ready3, 2'b01 << r);
      held = 0; rsp_cyc = 0;
      for (int k = 1; k <= 10; k++) begin
        @(negedge gb_clk);
        if (k == 1) v3 = 2'b00;
        #1;
        if (addr3 == ra && busy3) held++;
        if (gbwe3) held = 100;
        if (rsp3 != 2'b00 && rsp_cyc == 0) begin
          rsp_cyc = k;
          chk($sformatf("lat3 rsp owner %0d", r), rsp3, 2'b01 << r);
          chk($sformatf("lat3 rdata %0d", r), rdata3, rd);
        end
      end
      chk($sformatf("lat3 held %0d", r), held, 5);
      chk($sformatf("lat3 rsp cycle %0d", r), rsp_cyc, 5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
